ram_copy_engine: RTL and testbench

//  Initiator for the RAM64 memory interface (in/load/address/out): copies LEN words from SRC to DST.

---
 rtl/ram_ctrl_pkg.sv | 16 +
 rtl/ram_copy_engine_if.sv | 30 +++
 rtl/ram_copy_engine.sv | 122 ++++++++++++
 tb/tb_ram_copy_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types and sizes for the RAM copy engine
// Purpose: FSM state type and RAM64 geometry constants.
// Ports: none (package).
package ram_ctrl_pkg;

    localparam int RAM64_ADDR_W = 6;
    localparam int RAM_DATA_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

endpackage

// File: rtl/ram_copy_engine_if.sv
// rtl/ram_copy_engine_if.sv - single-port RAM64 memory bus
// Purpose: bundles the address/write-data/write-enable/read-data wires of one RAM.
// Ports (modport master = initiator, slave = RAM):
//   mem_addr  word address
//   mem_in    write data
//   mem_load  write enable, RAM writes on rising clk edge
//   mem_out   combinational read data
interface ram_copy_engine_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in;
    logic              mem_load;
    logic [DATA_W-1:0] mem_out;

    modport master (
        output mem_addr,
        output mem_in,
        output mem_load,
        input  mem_out
    );

    modport slave (
        input  mem_addr,
        input  mem_in,
        input  mem_load,
        output mem_out
    );
endinterface

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - copies len words from src to dst in one RAM64
// Purpose: start/done controlled block copy, two cycles per word (READ then WRITE).
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset, forces IDLE
//   start  copy request, sampled only in IDLE
//   src    first source address, latched on accepted start
//   dst    first destination address, latched on accepted start
//   len    word count 0..2**ADDR_W, latched on accepted start
//   busy   high in READ/WRITE/DONE
//   done   one-cycle completion pulse
//   mem    master side of the RAM bus
module ram_copy_engine
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM64_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    ram_copy_engine_if.master mem
);

    copy_state_t       state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;

    // index is one bit wider than an address so that a full 2**ADDR_W copy terminates
    logic [ADDR_W:0]   index_inc;
    assign index_inc = index_q + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        index_d = index_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    index_d = '0;
                    state_d = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                data_d  = mem.mem_out;
                state_d = WRITE;
            end
            WRITE: begin
                index_d = index_inc;
                state_d = (index_inc == len_q) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode registered state only, so mem_load cannot glitch and
    // falls with the asynchronous reset.
    always_comb begin
        mem.mem_addr = '0;
        mem.mem_in   = '0;
        mem.mem_load = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            READ: begin
                mem.mem_addr = src_q + index_q[ADDR_W-1:0];
                busy         = 1'b1;
            end
            WRITE: begin
                mem.mem_addr = dst_q + index_q[ADDR_W-1:0];
                mem.mem_in   = data_q;
                mem.mem_load = 1'b1;
                busy         = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - self-checking bench for ram_copy_engine with a RAM64 model
module tb_ram_copy_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  src;
    logic [5:0]  dst;
    logic [6:0]  len;
    logic        busy;
    logic        done;

    ram_copy_engine_if #(.ADDR_W(6), .DATA_W(16)) mem_if ();

    ram_copy_engine #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .mem   (mem_if.master)
    );

    // RAM64 with a backdoor port muxed in front of the engine's port
    logic [15:0] ram [0:63];
    logic        bd_en;
    logic [5:0]  bd_addr;
    logic [15:0] bd_data;
    logic [5:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_load;

    assign ram_addr       = bd_en ? bd_addr : mem_if.mem_addr;
    assign ram_wdata      = bd_en ? bd_data : mem_if.mem_in;
    assign ram_load       = bd_en ? 1'b1    : mem_if.mem_load;
    assign mem_if.mem_out = ram[ram_addr];

    always @(posedge clk) begin
        if (ram_load) ram[ram_addr] <= ram_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int load_cnt;
    int done_cnt;
    always @(negedge clk) begin
        if (mem_if.mem_load) load_cnt <= load_cnt + 1;
        if (done)            done_cnt <= done_cnt + 1;
    end

    logic [15:0] ref_mem [0:63];
    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        bd_en   = 1'b1;
        bd_addr = a;
        bd_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    // Reference: ascending word-by-word copy with address wrap
    task automatic model_copy(input logic [5:0] s, input logic [5:0] d, input int l);
        for (int i = 0; i < l; i++) begin
            logic [5:0] sa;
            logic [5:0] da;
            sa = s + 6'(i);
            da = d + 6'(i);
            ref_mem[da] = ref_mem[sa];
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 64; i++) begin
            checks++;
            assert (ram[i] === ref_mem[i]) else begin
                failures++;
                $error("FAIL %s word=%0d observed=%0h expected=%0h", tag, i, ram[i], ref_mem[i]);
            end
        end
    endtask

    // Issues one copy; poke re-asserts start with other operands while busy.
    task automatic run_copy(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l,
                            input bit poke, input string tag);
        int lat;
        int d0;
        @(negedge clk);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        d0    = done_cnt;
        start = 1'b0;
        src   = 6'($urandom);
        dst   = 6'($urandom);
        len   = 7'($urandom_range(1, 64));
        while (!done && lat < 300) begin
            if (poke && lat == 3) begin
                start = 1'b1;
                src   = s + 6'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, 2 * int'(l));
        model_copy(s, d, int'(l));
        @(negedge clk);
        check({tag, "_done_width"}, {30'd0, done, busy}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check_mem(tag);
    endtask

    initial begin
        int l0;
        checks   = 0;
        failures = 0;
        load_cnt = 0;
        done_cnt = 0;
        reset    = 1'b1;
        start    = 1'b0;
        src      = '0;
        dst      = '0;
        len      = '0;
        bd_en    = 1'b0;
        bd_addr  = '0;
        bd_data  = '0;

        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_load", mem_if.mem_load, 1'b0);
        check("reset_addr", mem_if.mem_addr, 6'd0);
        check("reset_in",   mem_if.mem_in, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) bd_write(6'(i), 16'h0000);

        // 1: basic copy
        bd_write(6'd0, 16'd1);
        bd_write(6'd1, 16'd2);
        bd_write(6'd2, 16'd3);
        bd_write(6'd3, 16'd4);
        run_copy(6'd0, 6'd10, 7'd4, 1'b0, "basic");
        check("basic_m10", ram[10], 16'd1);
        check("basic_m13", ram[13], 16'd4);
        check("basic_m0",  ram[0],  16'd1);

        // 2: zero length
        @(negedge clk);
        #1;
        l0 = load_cnt;
        run_copy(6'd5, 6'd20, 7'd0, 1'b0, "len0");
        check("len0_no_load", load_cnt - l0, 0);

        // 3: source wrap
        bd_write(6'd62, 16'hAAAA);
        bd_write(6'd63, 16'hBBBB);
        bd_write(6'd0,  16'hCCCC);
        run_copy(6'd62, 6'd30, 7'd3, 1'b0, "wrap");
        check("wrap_m30", ram[30], 16'hAAAA);
        check("wrap_m31", ram[31], 16'hBBBB);
        check("wrap_m32", ram[32], 16'hCCCC);

        // 4: forward overlap propagates
        bd_write(6'd0, 16'd7);
        bd_write(6'd1, 16'd8);
        run_copy(6'd0, 6'd1, 7'd2, 1'b0, "overlap");
        check("overlap_m1", ram[1], 16'd7);
        check("overlap_m2", ram[2], 16'd7);

        // 5: start during busy is ignored
        run_copy(6'd40, 6'd48, 7'd4, 1'b1, "busy_start");

        // 6: reset during the second WRITE
        for (int i = 0; i < 4; i++) bd_write(6'(20 + i), 16'(16'h1230 + i));
        @(negedge clk);
        l0 = done_cnt;
        start = 1'b1;
        src   = 6'd20;
        dst   = 6'd44;
        len   = 7'd4;
        @(posedge clk);                 // accept
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);      // READ, WRITE0, READ -> now in WRITE1
        #1;
        check("rst_pre_load", mem_if.mem_load, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_load", mem_if.mem_load, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        model_copy(6'd20, 6'd44, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_no_done", done_cnt - l0, 0);
        check_mem("rst_partial");
        run_copy(6'd20, 6'd50, 7'd4, 1'b0, "post_reset");

        // randomized copies
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) bd_write(6'(i), 16'($urandom));
            run_copy(6'($urandom), 6'($urandom),
                     (t == 0) ? 7'd64 : 7'($urandom_range(0, 64)), 1'b0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
